ssd_scanner: RTL
================

Name: ssd_scanner

Overview:
- Downstream consumer of the game top's four digit/enable pairs.
- Time-multiplexes them onto one shared active-low 7-segment bus with active-low per-digit anodes, on the fast board clock.
- Snapshots all four digits once per frame so a frame never mixes old and new values.
- Inserts a per-slot blanking guard to suppress ghosting; emits a frame-start strobe.

Parameters:
- TICKS_PER_DIGIT, 25000: clk_i cycles per digit slot. Legal range >= 2.
- BLANK_TICKS, 1000: cycles at the start of each slot with all anodes off. Legal range 0 <= BLANK_TICKS < TICKS_PER_DIGIT; an elaboration assertion enforces it.

Ports:
- clk_i  in  1  board clock
- rst_ni  in  1  reset, synchronous, active-low
- digit0_en_i  in  1  digit 0 enable (0 = blank)
- digit0_i  in  4  digit 0 hex value
- digit1_en_i  in  1  digit 1 enable
- digit1_i  in  4  digit 1 hex value
- digit2_en_i  in  1  digit 2 enable
- digit2_i  in  4  digit 2 hex value
- digit3_en_i  in  1  digit 3 enable
- digit3_i  in  4  digit 3 hex value
- anodes_o  out  4  active-low digit select; bit n = digit n
- segments_o  out  7  active-low segments, bit order {g,f,e,d,c,b,a}
- frame_o  out  1  one-cycle pulse at frame start

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is synchronous and active-low.
- Reset values:
  - tick_q = 0, slot_q = 0.
  - Snapshot: all enables 0, values 0.
  - anodes_o = 4'hF, segments_o = 7'h7F, frame_o = 0.
  - Reset asserted mid-frame takes effect on the next edge; the display is dark the following cycle.
- Counters:
  - tick_q counts 0..TICKS_PER_DIGIT-1, then wraps to 0.
  - On each tick wrap, slot_q advances 0->1->2->3->0 (2-bit wrap).
- Snapshot:
  - Captured on the edge where tick_q == TICKS_PER_DIGIT-1 and slot_q == 3, i.e. the final cycle of the frame.
  - All eight inputs are captured together.
  - Inputs are ignored at all other times.
  - The first frame after reset displays the reset (blank) snapshot.
- Output registers (1-cycle latency): on each edge, from the current tick_q, slot_q and snapshot:
  - If tick_q < BLANK_TICKS: anodes_o = 4'hF, segments_o = 7'h7F.
  - Else if snapshot enable[slot_q] == 0: anodes_o = 4'hF, segments_o = 7'h7F.
  - Else: anodes_o = ~(4'b0001 << slot_q), segments_o = decode(snapshot value[slot_q]).
  - At most one anode is low in any cycle.
- Decode, as active-high hex then bitwise inverted:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Examples on segments_o: '0' -> 7'h40, '8' -> 7'h00, 'F' -> 7'h0E.
- frame_o:
  - Registered; high for exactly one cycle, on the edge where slot_q == 0 and tick_q == 0.
  - Therefore it first rises one cycle after reset deassertion, then once every 4*TICKS_PER_DIGIT cycles.
- Other rules:
  - Input changes never glitch the outputs mid-frame.
  - Toggling an enable mid-frame takes effect only in the next frame.
  - Input values wider than the legal range do not exist (4-bit field); all 16 codes decode.
  - With BLANK_TICKS = 0 there is no guard; the anode is active for the full slot.

Decomposition:
- stop_it_pkg additions:
  - Constants SEG_BLANK = 7'h7F and AN_OFF = 4'hF.
  - Typedef seg_t (logic [6:0]).
  - Typedef digit_snap_t: packed struct of en plus 4-bit val, with an array of 4.
- Sub-module hex_to_seg: combinational 4-bit -> active-low seg_t decoder, instantiated once on the muxed snapshot value.

Test Plan (TICKS_PER_DIGIT=8, BLANK_TICKS=2 unless noted):
- Reset, all enables 1, digits 0,1,2,3 held static -> first frame (cycles 1..32) anodes_o = 4'hF throughout. Second frame, slot 0 ticks 2..7: anodes_o = 4'hE, segments_o = 7'h40. Slot 3: anodes_o = 4'h7, segments_o = 7'h30. frame_o pulses at cycle 1 and every 32 cycles thereafter.
- Guard: in every slot, the first 2 cycles show anodes_o = 4'hF, segments_o = 7'h7F. BLANK_TICKS=0 -> no dark cycles; anode low for all 8.
- digit2_en_i = 0 with other enables 1 -> slot 2 fully dark (4'hF, 7'h7F); slots 0, 1, 3 unaffected.
- Change digit0_i from 5 to F during slot 1 of frame N -> frame N keeps showing 7'h12 in slot 0. Frame N+1 slot 0 shows 7'h0E.
- Assert rst_ni = 0 for 1 cycle mid-slot 2 -> next cycle anodes_o = 4'hF, segments_o = 7'h7F. Counters restart at 0. A blank frame follows, then normal display.
- Sweep all 16 codes through digit3 -> segments_o matches the decode table; assert at most one anodes_o bit is low every cycle.

Source files
------------

// File: rtl/ssd_scanner_pkg.sv
// Shared types and constants for the multiplexed
// seven-segment scanner.
package ssd_scanner_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg_t;

  localparam seg_t       SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef struct packed {
    logic       en;
    logic [3:0] val;
  } digit_snap_t;

  typedef digit_snap_t [NUM_DIGITS-1:0] snap_arr_t;

  // Active-low one-hot anode pattern for a slot
  function automatic logic [3:0] an_sel(
    input logic [1:0] slot
  );
    return ~(4'b0001 << slot);
  endfunction

endpackage

// File: rtl/ssd_scanner_hex.sv
// Hex nibble to active-low seven-segment pattern.
// Bit order {g,f,e,d,c,b,a}.
module hex_to_seg
  import ssd_scanner_pkg::*;
(
  input  logic [3:0] i_val,
  output seg_t       o_seg
);

  seg_t w_hi;

  always_comb begin
    w_hi = 7'h00;
    unique case (i_val)
      4'h0: w_hi = 7'h3F;
      4'h1: w_hi = 7'h06;
      4'h2: w_hi = 7'h5B;
      4'h3: w_hi = 7'h4F;
      4'h4: w_hi = 7'h66;
      4'h5: w_hi = 7'h6D;
      4'h6: w_hi = 7'h7D;
      4'h7: w_hi = 7'h07;
      4'h8: w_hi = 7'h7F;
      4'h9: w_hi = 7'h6F;
      4'hA: w_hi = 7'h77;
      4'hB: w_hi = 7'h7C;
      4'hC: w_hi = 7'h39;
      4'hD: w_hi = 7'h5E;
      4'hE: w_hi = 7'h79;
      4'hF: w_hi = 7'h71;
    endcase
  end

  assign o_seg = ~w_hi;

endmodule

// File: rtl/ssd_scanner.sv
// Four-digit time-multiplexed seven-segment driver
// with per-frame snapshot and anti-ghosting guard.
module ssd_scanner
  import ssd_scanner_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 25000,
  parameter int BLANK_TICKS     = 1000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       digit0_en_i,
  input  logic [3:0] digit0_i,
  input  logic       digit1_en_i,
  input  logic [3:0] digit1_i,
  input  logic       digit2_en_i,
  input  logic [3:0] digit2_i,
  input  logic       digit3_en_i,
  input  logic [3:0] digit3_i,
  output logic [3:0] anodes_o,
  output logic [6:0] segments_o,
  output logic       frame_o
);

  localparam int TW = $clog2(TICKS_PER_DIGIT);
  localparam logic [TW-1:0] TICK_LAST =
    TW'(TICKS_PER_DIGIT - 1);

  generate
    if (TICKS_PER_DIGIT < 2 || BLANK_TICKS < 0 ||
        BLANK_TICKS >= TICKS_PER_DIGIT) begin : g_bad
      $error("ssd_scanner: illegal tick parameters");
    end
  endgenerate

  logic [TW-1:0] r_tick;
  logic [1:0]    r_slot;
  snap_arr_t     r_snap;
  logic [3:0]    r_anodes;
  seg_t          r_segs;
  logic          r_frame;

  logic          w_tick_wrap;
  logic          w_frame_end;
  logic          w_guard;
  snap_arr_t     w_inputs;
  digit_snap_t   w_cur;
  seg_t          w_seg;

  assign w_tick_wrap = (r_tick == TICK_LAST);
  assign w_frame_end = w_tick_wrap && (r_slot == 2'd3);

  // Zero guard folds away instead of a constant compare
  generate
    if (BLANK_TICKS == 0) begin : g_noguard
      assign w_guard = 1'b0;
    end else begin : g_guard
      assign w_guard = (r_tick < TW'(BLANK_TICKS));
    end
  endgenerate

  assign w_inputs[0] = '{en: digit0_en_i, val: digit0_i};
  assign w_inputs[1] = '{en: digit1_en_i, val: digit1_i};
  assign w_inputs[2] = '{en: digit2_en_i, val: digit2_i};
  assign w_inputs[3] = '{en: digit3_en_i, val: digit3_i};

  assign w_cur = r_snap[r_slot];

  hex_to_seg u_dec (
    .i_val (w_cur.val),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_tick   <= '0;
      r_slot   <= '0;
      r_snap   <= '0;
      r_anodes <= AN_OFF;
      r_segs   <= SEG_BLANK;
      r_frame  <= 1'b0;
    end else begin
      r_tick <= w_tick_wrap ? '0 : r_tick + 1'b1;
      if (w_tick_wrap)
        r_slot <= r_slot + 1'b1;
      if (w_frame_end)
        r_snap <= w_inputs;
      if (w_guard || !w_cur.en) begin
        r_anodes <= AN_OFF;
        r_segs   <= SEG_BLANK;
      end else begin
        r_anodes <= an_sel(r_slot);
        r_segs   <= w_seg;
      end
      r_frame <= (r_tick == '0) && (r_slot == 2'd0);
    end
  end

  assign anodes_o   = r_anodes;
  assign segments_o = r_segs;
  assign frame_o    = r_frame;

endmodule
